// File: rtl/bcd_serial_encoder_pkg.sv
// Shared types, constants and helpers for the serial binary-to-BCD encoder.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic [3:0] add3_if_gt4(input logic [3:0] digit);
        if (digit > 4'd4) begin
            return digit + 4'd3;
        end else begin
            return digit;
        end
    endfunction

    // Smallest digit count whose decimal range covers every BIN_W-bit value.
    function automatic int min_digits(input int bin_w);
        longint unsigned max_v;
        longint unsigned pow_v;
        int              w;
        int              d;
        w     = (bin_w < 1) ? 1 : ((bin_w > 32) ? 32 : bin_w);
        max_v = (64'd1 << w) - 64'd1;
        pow_v = 64'd10;
        d     = 1;
        for (int i = 0; i < 10; i++) begin
            if (pow_v <= max_v) begin
                pow_v = pow_v * 64'd10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_serial_encoder_if.sv
// Start/busy/done handshake and result bus of the serial BCD encoder.
interface bcd_serial_encoder_if
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);

    logic                        start;
    logic [BIN_W-1:0]            bin_in;
    logic                        busy;
    logic                        done;
    logic [DIGIT_W*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]           blank;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  blank
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output blank
    );

endinterface

// File: rtl/bcd_serial_encoder_digit_adj.sv
// Per-digit add-3 correction applied before each double-dabble shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = add3_if_gt4(digit_i);

endmodule

// File: rtl/bcd_serial_encoder.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with a registered result and leading-zero blanking mask.
module bcd_serial_encoder
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_serial_encoder_if.slave  bus
);

    localparam int WORK_W = DIGIT_W * DIGITS;
    localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    if ((BIN_W < 1) || (BIN_W > 32)) begin : g_bad_bin_w
        $error("bcd_serial_encoder: BIN_W must be within 1..32");
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bcd_serial_encoder: DIGITS too small for BIN_W");
    end

    state_e              state_q, state_d;
    logic [BIN_W-1:0]    shift_q, shift_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WORK_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d;

    logic [WORK_W-1:0]   adj_s;
    logic [WORK_W-1:0]   shifted_s;
    logic [DIGITS-1:0]   blank_s;
    logic                all_zero_s;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (work_q[d*DIGIT_W +: DIGIT_W]),
            .digit_o (adj_s[d*DIGIT_W +: DIGIT_W])
        );
    end

    // The top corrected bit is always zero for legal DIGITS, so truncation is lossless.
    assign shifted_s = WORK_W'({adj_s, shift_q[BIN_W-1]});

    // Leading-zero mask of the post-shift value, scanning from the top digit down.
    always_comb begin
        all_zero_s = 1'b1;
        blank_s    = {DIGITS{1'b0}};
        for (int d = DIGITS - 1; d >= 0; d--) begin
            all_zero_s = all_zero_s & (shifted_s[d*DIGIT_W +: DIGIT_W] == 4'd0);
            if (d > 0) begin
                blank_s[d] = all_zero_s;
            end else begin
                blank_s[d] = 1'b0;
            end
        end
    end

    // Next-state logic for the IDLE/SHIFT sequencer and result registers.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    shift_d = bus.bin_in;
                    work_d  = {WORK_W{1'b0}};
                    cnt_d   = CNT_W'(BIN_W - 1);
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                shift_d = shift_q << 1;
                work_d  = shifted_s;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = shifted_s;
                    blank_d = blank_s;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= {BIN_W{1'b0}};
            work_q  <= {WORK_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= {WORK_W{1'b0}};
            blank_q <= BLANK_RST;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;
    assign bus.blank   = blank_q;

endmodule
